// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: frequency-sweep sequencer that drives an NCO phase
// increment (FCW). It steps from a start FCW to a stop FCW in fixed
// increments and holds each value for a programmable dwell. A sweep can
// run once or repeat until aborted.
// Optional build macro SWEEP_TRIANGLE_EN: after reaching stop, the sweep
// turns around and descends back to start instead of ending at stop.
module nco_sweep_ctrl #(
    parameter int FCW_W   = 16,
    parameter int DWELL_W = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FCW_W-1:0]   cfg_start_fcw,
    input  logic [FCW_W-1:0]   cfg_stop_fcw,
    input  logic [FCW_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_loop,
    output logic [FCW_W-1:0]   fcw_out,
    output logic               fcw_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, DWELL, STEP, DONE} state_t;

    state_t             state;
    logic [FCW_W-1:0]   start_l;
    logic [FCW_W-1:0]   stop_l;
    logic [FCW_W-1:0]   step_l;
    logic [DWELL_W-1:0] dwell_l;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               loop_l;
    logic               single_l;   // start >= stop: a one-value sweep

    // One extra bit so the sum never wraps before it is clamped to stop
    logic [FCW_W:0]     next_up;
    logic [FCW_W-1:0]   fcw_up;
    logic               at_end;

`ifdef SWEEP_TRIANGLE_EN
    logic               dir_up;
    logic [FCW_W:0]     next_dn;
    logic [FCW_W-1:0]   fcw_dn;
    logic               turn;
`endif

    assign next_up = {1'b0, fcw_out} + {1'b0, step_l};
    assign fcw_up  = (next_up >= {1'b0, stop_l}) ? stop_l : next_up[FCW_W-1:0];

`ifdef SWEEP_TRIANGLE_EN
    // A borrow in the top bit means the difference went below zero
    assign next_dn = {1'b0, fcw_out} - {1'b0, step_l};
    assign fcw_dn  = (next_dn[FCW_W] || (next_dn[FCW_W-1:0] <= start_l)) ?
                     start_l : next_dn[FCW_W-1:0];
    assign turn    = dir_up && (fcw_out == stop_l);
    assign at_end  = single_l || (!dir_up && (fcw_out == start_l));
`else
    assign at_end  = single_l || (fcw_out == stop_l);
`endif

    // Sweep sequencer: latches the configuration, counts dwell, steps the FCW
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            fcw_out   <= '0;
            fcw_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dwell_cnt <= '0;
            start_l   <= '0;
            stop_l    <= '0;
            step_l    <= '0;
            dwell_l   <= '0;
            loop_l    <= 1'b0;
            single_l  <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
            dir_up    <= 1'b1;
`endif
        end else if (abort) begin
            // fcw_out is left alone so the NCO keeps its current frequency
            state     <= IDLE;
            fcw_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            fcw_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        start_l   <= cfg_start_fcw;
                        stop_l    <= cfg_stop_fcw;
                        step_l    <= (cfg_step == '0) ? FCW_W'(1) : cfg_step;
                        dwell_l   <= cfg_dwell;
                        loop_l    <= cfg_loop;
                        single_l  <= (cfg_start_fcw >= cfg_stop_fcw);
                        fcw_out   <= cfg_start_fcw;
                        fcw_valid <= 1'b1;
                        busy      <= 1'b1;
                        dwell_cnt <= '0;
                        state     <= DWELL;
`ifdef SWEEP_TRIANGLE_EN
                        dir_up    <= 1'b1;
`endif
                    end
                end
                DWELL: begin
                    if (dwell_cnt == dwell_l) begin
                        if (at_end) begin
                            if (loop_l) begin
                                fcw_out   <= start_l;
                                fcw_valid <= 1'b1;
                                dwell_cnt <= '0;
`ifdef SWEEP_TRIANGLE_EN
                                dir_up    <= 1'b1;
`endif
                            end else begin
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end else begin
`ifdef SWEEP_TRIANGLE_EN
                            if (turn) begin
                                dir_up <= 1'b0;
                            end
`endif
                            state <= STEP;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end
                end
                STEP: begin
`ifdef SWEEP_TRIANGLE_EN
                    fcw_out <= dir_up ? fcw_up : fcw_dn;
`else
                    fcw_out <= fcw_up;
`endif
                    fcw_valid <= 1'b1;
                    dwell_cnt <= '0;
                    state     <= DWELL;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl. Expected (value, cycle) pairs
// for each fcw_valid pulse are queued before a sweep is started and
// compared against the pulses the DUT produces.
module tb_nco_sweep_ctrl;

    localparam int FCW_W   = 16;
    localparam int DWELL_W = 16;

    logic               sys_clk = 1'b0;
    logic               sys_rst = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [FCW_W-1:0]   cfg_start_fcw = '0;
    logic [FCW_W-1:0]   cfg_stop_fcw = '0;
    logic [FCW_W-1:0]   cfg_step = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic               cfg_loop = 1'b0;
    logic [FCW_W-1:0]   fcw_out;
    logic               fcw_valid;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;

    int exp_fcw[$];
    int exp_cyc[$];
    int got_fcw[$];
    int got_cyc[$];
    int done_cyc;
    int done_cnt;
    bit hit;
    bit busy_gap;
    logic busy_after;
    int ef, ec, gf, gc;

    nco_sweep_ctrl #(.FCW_W(FCW_W), .DWELL_W(DWELL_W)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .start         (start),
        .abort         (abort),
        .cfg_start_fcw (cfg_start_fcw),
        .cfg_stop_fcw  (cfg_stop_fcw),
        .cfg_step      (cfg_step),
        .cfg_dwell     (cfg_dwell),
        .cfg_loop      (cfg_loop),
        .fcw_out       (fcw_out),
        .fcw_valid     (fcw_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic set_cfg(input int s, input int p, input int st, input int dw, input bit lp);
        cfg_start_fcw = FCW_W'(s);
        cfg_stop_fcw  = FCW_W'(p);
        cfg_step      = FCW_W'(st);
        cfg_dwell     = DWELL_W'(dw);
        cfg_loop      = lp;
    endtask

    task automatic push_exp(input int v, input int c);
        exp_fcw.push_back(v);
        exp_cyc.push_back(c);
    endtask

    // Start pulse; returns at the first negedge after the accepting edge (cycle 0)
    task automatic pulse_start();
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    // Record DUT events until n_valid pulses, or one cycle past done (n_valid==0).
    // start is pulsed at cycle 'poke' to exercise start-while-busy.
    task automatic collect(input int max_cyc, input int n_valid, input int poke);
        got_fcw.delete();
        got_cyc.delete();
        done_cyc = -1;
        done_cnt = 0;
        hit = 1'b0;
        busy_gap = 1'b0;
        busy_after = 1'bx;
        for (int c = 0; c < max_cyc; c++) begin
            if (fcw_valid) begin
                got_fcw.push_back(int'(fcw_out));
                got_cyc.push_back(c);
            end
            if (done) begin
                if (done_cyc < 0) done_cyc = c;
                done_cnt++;
            end
            if (!busy && done_cyc < 0) busy_gap = 1'b1;
            if (n_valid > 0 && got_fcw.size() == n_valid) begin
                hit = 1'b1;
                break;
            end
            if (n_valid == 0 && done_cyc >= 0 && c > done_cyc) begin
                busy_after = busy;
                hit = 1'b1;
                break;
            end
            start = (c == poke);
            @(negedge sys_clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (fcw_out !== '0) begin errors++; $display("FAIL reset_fcw got %0d want 0", fcw_out); end
        checks++; if (fcw_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", fcw_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    endtask

    // 100..130 step 10, dwell 2; cfg changed and start re-pulsed mid-sweep
    task automatic test_basic();
        set_cfg(100, 130, 10, 2, 1'b0);
        push_exp(100, 0); push_exp(110, 4); push_exp(120, 8); push_exp(130, 12);
        pulse_start();
        set_cfg(7, 9, 1, 0, 1'b1);
        collect(100, 0, 2);
        checks++; if (!hit) begin errors++; $display("FAIL basic_timeout got no done want done"); end
        checks++; if (got_fcw.size() !== exp_fcw.size()) begin errors++; $display("FAIL basic_count got %0d want %0d", got_fcw.size(), exp_fcw.size()); end
        while (exp_fcw.size() > 0) begin
            ef = exp_fcw.pop_front(); ec = exp_cyc.pop_front();
            if (got_fcw.size() > 0) begin gf = got_fcw.pop_front(); gc = got_cyc.pop_front(); end
            else begin gf = -1; gc = -1; end
            checks++; if (gf !== ef || gc !== ec) begin errors++; $display("FAIL basic_seq got %0d@%0d want %0d@%0d", gf, gc, ef, ec); end
        end
        checks++; if (done_cyc !== 15) begin errors++; $display("FAIL basic_done_cycle got %0d want 15", done_cyc); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_width got %0d want 1", done_cnt); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy_after); end
        checks++; if (busy_gap !== 1'b0) begin errors++; $display("FAIL basic_busy_gap got %b want 0", busy_gap); end
    endtask

    // Top-of-range sweep must clamp at stop instead of wrapping
    task automatic test_no_wrap();
        set_cfg(65530, 65535, 10, 1, 1'b0);
        push_exp(65530, 0); push_exp(65535, 3);
        pulse_start();
        collect(100, 0, 5);
        checks++; if (!hit) begin errors++; $display("FAIL nowrap_timeout got no done want done"); end
        checks++; if (got_fcw.size() !== exp_fcw.size()) begin errors++; $display("FAIL nowrap_count got %0d want %0d", got_fcw.size(), exp_fcw.size()); end
        while (exp_fcw.size() > 0) begin
            ef = exp_fcw.pop_front(); ec = exp_cyc.pop_front();
            if (got_fcw.size() > 0) begin gf = got_fcw.pop_front(); gc = got_cyc.pop_front(); end
            else begin gf = -1; gc = -1; end
            checks++; if (gf !== ef || gc !== ec) begin errors++; $display("FAIL nowrap_seq got %0d@%0d want %0d@%0d", gf, gc, ef, ec); end
        end
        checks++; if (done_cyc !== 5) begin errors++; $display("FAIL nowrap_done_cycle got %0d want 5", done_cyc); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL nowrap_busy_after got %b want 0", busy_after); end
    endtask

    // Looping sweep, aborted on the second appearance of 10
    task automatic test_loop_abort();
        bit stray;
        set_cfg(0, 20, 10, 0, 1'b1);
        push_exp(0, 0); push_exp(10, 2); push_exp(20, 4); push_exp(0, 5); push_exp(10, 7);
        pulse_start();
        collect(100, 5, -1);
        checks++; if (!hit) begin errors++; $display("FAIL loop_timeout got %0d pulses want 5", got_fcw.size()); end
        while (exp_fcw.size() > 0) begin
            ef = exp_fcw.pop_front(); ec = exp_cyc.pop_front();
            if (got_fcw.size() > 0) begin gf = got_fcw.pop_front(); gc = got_cyc.pop_front(); end
            else begin gf = -1; gc = -1; end
            checks++; if (gf !== ef || gc !== ec) begin errors++; $display("FAIL loop_seq got %0d@%0d want %0d@%0d", gf, gc, ef, ec); end
        end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL loop_done got %0d pulses want 0", done_cnt); end
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (fcw_out !== 16'd10) begin errors++; $display("FAIL abort_hold got %0d want 10", fcw_out); end
        checks++; if (fcw_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_pulses got valid=%b done=%b want 0 0", fcw_valid, done); end
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            if (fcw_valid || done || busy) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL abort_idle got activity=%b want 0", stray); end
    endtask

    // start and abort together in IDLE: abort wins, fcw_out holds
    task automatic test_start_abort(input int hold);
        bit stray;
        set_cfg(200, 300, 5, 0, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || fcw_valid !== 1'b0) begin errors++; $display("FAIL start_abort got busy=%b valid=%b want 0 0", busy, fcw_valid); end
        checks++; if (fcw_out !== FCW_W'(hold)) begin errors++; $display("FAIL start_abort_hold got %0d want %0d", fcw_out, hold); end
        stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            if (fcw_valid || busy || done) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL start_abort_idle got activity=%b want 0", stray); end
    endtask

    // start >= stop: single value dwelt once, then done
    task automatic test_start_ge_stop();
        set_cfg(50, 40, 5, 3, 1'b0);
        push_exp(50, 0);
        pulse_start();
        collect(100, 0, -1);
        checks++; if (!hit) begin errors++; $display("FAIL gestop_timeout got no done want done"); end
        checks++; if (got_fcw.size() !== exp_fcw.size()) begin errors++; $display("FAIL gestop_count got %0d want %0d", got_fcw.size(), exp_fcw.size()); end
        while (exp_fcw.size() > 0) begin
            ef = exp_fcw.pop_front(); ec = exp_cyc.pop_front();
            if (got_fcw.size() > 0) begin gf = got_fcw.pop_front(); gc = got_cyc.pop_front(); end
            else begin gf = -1; gc = -1; end
            checks++; if (gf !== ef || gc !== ec) begin errors++; $display("FAIL gestop_seq got %0d@%0d want %0d@%0d", gf, gc, ef, ec); end
        end
        checks++; if (done_cyc !== 4) begin errors++; $display("FAIL gestop_done_cycle got %0d want 4", done_cyc); end
    endtask

    // step of 0 behaves as step of 1
    task automatic test_step_zero();
        set_cfg(0, 3, 0, 0, 1'b0);
        push_exp(0, 0); push_exp(1, 2); push_exp(2, 4); push_exp(3, 6);
        pulse_start();
        collect(100, 0, -1);
        checks++; if (!hit) begin errors++; $display("FAIL step0_timeout got no done want done"); end
        checks++; if (got_fcw.size() !== exp_fcw.size()) begin errors++; $display("FAIL step0_count got %0d want %0d", got_fcw.size(), exp_fcw.size()); end
        while (exp_fcw.size() > 0) begin
            ef = exp_fcw.pop_front(); ec = exp_cyc.pop_front();
            if (got_fcw.size() > 0) begin gf = got_fcw.pop_front(); gc = got_cyc.pop_front(); end
            else begin gf = -1; gc = -1; end
            checks++; if (gf !== ef || gc !== ec) begin errors++; $display("FAIL step0_seq got %0d@%0d want %0d@%0d", gf, gc, ef, ec); end
        end
        checks++; if (done_cyc !== 7) begin errors++; $display("FAIL step0_done_cycle got %0d want 7", done_cyc); end
    endtask

    // sys_rst in the middle of a dwell discards the sweep
    task automatic test_reset_mid();
        bit stray;
        set_cfg(100, 130, 10, 5, 1'b0);
        pulse_start();
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        checks++; if (fcw_out !== '0) begin errors++; $display("FAIL rstmid_fcw got %0d want 0", fcw_out); end
        checks++; if (busy !== 1'b0 || fcw_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got busy=%b valid=%b done=%b want 0 0 0", busy, fcw_valid, done); end
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            if (fcw_valid || busy || done) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL rstmid_discard got activity=%b want 0", stray); end
    endtask

`ifdef SWEEP_TRIANGLE_EN
    // Triangle: up to stop, back down to start, stop not repeated
    task automatic test_triangle();
        set_cfg(0, 30, 10, 1, 1'b0);
        push_exp(0, 0); push_exp(10, 3); push_exp(20, 6); push_exp(30, 9);
        push_exp(20, 12); push_exp(10, 15); push_exp(0, 18);
        pulse_start();
        collect(200, 0, -1);
        checks++; if (!hit) begin errors++; $display("FAIL tri_timeout got no done want done"); end
        checks++; if (got_fcw.size() !== exp_fcw.size()) begin errors++; $display("FAIL tri_count got %0d want %0d", got_fcw.size(), exp_fcw.size()); end
        while (exp_fcw.size() > 0) begin
            ef = exp_fcw.pop_front(); ec = exp_cyc.pop_front();
            if (got_fcw.size() > 0) begin gf = got_fcw.pop_front(); gc = got_cyc.pop_front(); end
            else begin gf = -1; gc = -1; end
            checks++; if (gf !== ef || gc !== ec) begin errors++; $display("FAIL tri_seq got %0d@%0d want %0d@%0d", gf, gc, ef, ec); end
        end
        checks++; if (done_cyc !== 20) begin errors++; $display("FAIL tri_done_cycle got %0d want 20", done_cyc); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL tri_busy_after got %b want 0", busy_after); end
    endtask
`endif

    initial begin
        sys_rst = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        test_reset();
        sys_rst = 1'b0;
        @(negedge sys_clk);
`ifdef SWEEP_TRIANGLE_EN
        test_start_ge_stop();
        test_start_abort(50);
        test_triangle();
        test_reset_mid();
`else
        test_basic();
        test_no_wrap();
        test_loop_abort();
        test_start_abort(10);
        test_start_ge_stop();
        test_step_zero();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter FCW_W, default 16, the frequency control word width, where fout = FCW*fclk/2^FCW_W.
REQ-002 SHALL have parameter DWELL_W, default 16, the dwell counter width.
REQ-003 SHALL have port sys_clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port sys_rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a sweep.
REQ-006 SHALL have port abort, input, 1, which stops the sweep immediately.
REQ-007 SHALL have port cfg_start_fcw, input, FCW_W, the first FCW of the sweep.
REQ-008 SHALL have port cfg_stop_fcw, input, FCW_W, the final FCW of the sweep.
REQ-009 SHALL have port cfg_step, input, FCW_W, the FCW increment.
REQ-010 SHALL have port cfg_dwell, input, DWELL_W, the hold time per FCW, equal to cfg_dwell+1 cycles.
REQ-011 SHALL have port cfg_loop, input, 1, which repeats the sweep until abort when set.
REQ-012 SHALL have port fcw_out, output, FCW_W, the FCW driven to the NCO phi_inc input.
REQ-013 SHALL have port fcw_valid, output, 1, a one-cycle pulse each time fcw_out changes or is reloaded.
REQ-014 SHALL have port busy, output, 1, high in every state other than IDLE.
REQ-015 SHALL have port done, output, 1, a one-cycle pulse when a non-looping sweep completes.

Function
REQ-016 SHALL implement states IDLE, DWELL, STEP and DONE.
REQ-017 SHALL, on start in IDLE, latch all cfg_* inputs; changes to cfg_* during a sweep are ignored.
REQ-018 SHALL, in the cycle after a start in IDLE, show fcw_out=cfg_start_fcw with fcw_valid=1 and enter DWELL.
REQ-019 SHALL hold each FCW in DWELL for exactly cfg_dwell+1 cycles, counted from the fcw_valid cycle, then enter STEP.
REQ-020 SHALL, in STEP, compute next = fcw_out + step at FCW_W+1 bits, with no wrap-around.
REQ-021 SHALL, if next >= stop, load stop; otherwise it loads next.
REQ-022 SHALL output the new FCW with fcw_valid=1 one cycle after STEP, then return to DWELL.
REQ-023 SHALL treat the sweep end as the completion of a dwell while fcw_out == stop.
REQ-024 SHALL, at sweep end with cfg_loop=1, reload start with fcw_valid=1 and enter DWELL.
REQ-025 SHALL, at sweep end with cfg_loop=0, enter DONE, pulse done for 1 cycle, then return to IDLE.
REQ-026 SHALL treat a latched step of 0 as 1.
REQ-027 SHALL, when latched start >= stop, output start only, dwell once, then apply the sweep-end rule.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL, on abort in any state, go to IDLE on the next cycle with no done and no fcw_valid, holding fcw_out.
REQ-030 SHALL give abort priority over a start in the same cycle.
REQ-031 SHALL hold fcw_out at its last value in IDLE, so the NCO keeps running.

Reset
REQ-032 SHALL, on sys_rst=1 at a clock edge, enter IDLE with fcw_out=0, fcw_valid=0, busy=0, done=0, dwell counter 0 and direction up.
REQ-033 SHALL give sys_rst priority over start and abort, and SHALL discard a sweep that is mid-operation.

Configuration
REQ-034 SHALL, with macro SWEEP_TRIANGLE_EN defined, reverse direction at stop and descend by step.
REQ-035 SHALL, with SWEEP_TRIANGLE_EN defined, compute next = fcw_out - step at FCW_W+1 bits and clamp at start when next <= start.
REQ-036 SHALL, with SWEEP_TRIANGLE_EN defined, treat the sweep end as a dwell completed at start after descending, with the loop/done rules unchanged.
REQ-037 SHALL, with SWEEP_TRIANGLE_EN defined, not repeat the stop value at the turnaround.
REQ-038 SHALL, without SWEEP_TRIANGLE_EN, sweep upward only as a sawtooth, and SHALL contain no direction logic.

Verification
REQ-039 SHALL cover: start=100, stop=130, step=10, dwell=2, loop=0 -> fcw_out 100,110,120,130, each held 3 cycles, 4 fcw_valid pulses, done 1 cycle after the last dwell, then busy=0.
REQ-040 SHALL cover: start=65530, stop=65535, step=10, FCW_W=16 -> fcw_out 65530 then 65535 with no wrap, then done.
REQ-041 SHALL cover: loop=1, start=0, stop=20, step=10, dwell=0 -> sequence 0,10,20,0,10,...; abort at the second 10 -> IDLE next cycle, fcw_out=10, no done.
REQ-042 SHALL cover: start=50, stop=40 -> single FCW 50 held cfg_dwell+1 cycles, then done; step=0 with start=0, stop=3 -> 0,1,2,3.
REQ-043 SHALL cover: start and abort asserted together in IDLE -> stays IDLE; sys_rst mid-DWELL -> fcw_out=0, busy=0 next cycle.
REQ-044 SHALL cover, with SWEEP_TRIANGLE_EN defined: start=0, stop=30, step=10 -> 0,10,20,30,20,10,0, then done.
